// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI arbiter: FSM encoding, AXI burst/response codes
// and a width helper for master-index signals.
package axi_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_A  = 3'd1;
    localparam logic [2:0] ST_RD_D  = 3'd2;
    localparam logic [2:0] ST_WR_AW = 3'd3;
    localparam logic [2:0] ST_WR_B  = 3'd4;

    // AXI4 encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // Width of an index into n masters; never below one bit so a single
    // master still has a legal (constant zero) index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_arb_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at or
// after ptr_i, searching cyclically, as both a one-hot vector and an index.
module axi_arb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] cand_s;
    logic           hit_s;
    logic           found_s;

    // Walk the requesters starting at the pointer and latch the first hit
    always_comb begin
        found_s  = 1'b0;
        idx_o    = '0;
        sum_s    = '0;
        cand_s   = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s   = {1'b0, ptr_i} + (IDX_W+1)'(i);
            cand_s  = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
            hit_s   = ~found_s & req_i[cand_s[IDX_W-1:0]];
            idx_o   = hit_s ? cand_s[IDX_W-1:0] : idx_o;
            found_s = found_s | hit_s;
        end
        valid_o  = found_s;
        onehot_o = found_s ? (NUM_REQ'(1'b1) << idx_o) : '0;
    end

endmodule

// File: rtl/axi_arb.sv
// AXI4 arbiter: merges NUM_MST simplified upstream masters onto one AXI4
// master port, one single-beat transaction at a time, round-robin granted.
module axi_arb
    import axi_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // upstream read address / data
    input  logic [NUM_MST-1:0]        s_ar_valid_i,
    input  logic [NUM_MST*ADDR_W-1:0] s_ar_addr_i,
    input  logic [NUM_MST*3-1:0]      s_ar_size_i,
    output logic [NUM_MST-1:0]        s_ar_ready_o,
    output logic [NUM_MST-1:0]        s_r_valid_o,
    output logic [DATA_W-1:0]         s_r_data_o,
    output logic [1:0]                s_r_resp_o,
    input  logic [NUM_MST-1:0]        s_r_ready_i,
    // upstream write address / data / response
    input  logic [NUM_MST-1:0]        s_aw_valid_i,
    input  logic [NUM_MST*ADDR_W-1:0] s_aw_addr_i,
    input  logic [NUM_MST*3-1:0]      s_aw_size_i,
    output logic [NUM_MST-1:0]        s_aw_ready_o,
    input  logic [NUM_MST-1:0]        s_w_valid_i,
    input  logic [NUM_MST*DATA_W-1:0] s_w_data_i,
    input  logic [NUM_MST*(DATA_W/8)-1:0] s_w_strb_i,
    output logic [NUM_MST-1:0]        s_w_ready_o,
    output logic [NUM_MST-1:0]        s_b_valid_o,
    output logic [1:0]                s_b_resp_o,
    input  logic [NUM_MST-1:0]        s_b_ready_i,
    // downstream AXI4 master
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ID_W-1:0]           m_awid,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W/8-1:0]       m_wstrb,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [ID_W-1:0]           m_bid,
    input  logic [1:0]                m_bresp,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ID_W-1:0]           m_arid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [ID_W-1:0]           m_rid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast
);

    localparam int IDX_W  = idx_width(NUM_MST);
    localparam int STRB_W = DATA_W / 8;

    logic [2:0]        state_q,   state_d;
    logic [IDX_W-1:0]  grant_q,   grant_d;
    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;

    logic [NUM_MST-1:0] req_s;
    logic [NUM_MST-1:0] pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [NUM_MST-1:0] grant_oh_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic               ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

    // Responses complete on the first beat; rlast and the returned ids carry
    // no information the arbiter needs.
    logic unused_s;
    assign unused_s = ^{m_rlast, m_rid, m_bid};

    // Per-master payload views
    logic [ADDR_W-1:0] ar_addr_a [NUM_MST];
    logic [2:0]        ar_size_a [NUM_MST];
    logic [ADDR_W-1:0] aw_addr_a [NUM_MST];
    logic [2:0]        aw_size_a [NUM_MST];
    logic [DATA_W-1:0] w_data_a  [NUM_MST];
    logic [STRB_W-1:0] w_strb_a  [NUM_MST];

    for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
        assign ar_addr_a[g] = s_ar_addr_i[g*ADDR_W +: ADDR_W];
        assign ar_size_a[g] = s_ar_size_i[g*3 +: 3];
        assign aw_addr_a[g] = s_aw_addr_i[g*ADDR_W +: ADDR_W];
        assign aw_size_a[g] = s_aw_size_i[g*3 +: 3];
        assign w_data_a[g]  = s_w_data_i[g*DATA_W +: DATA_W];
        assign w_strb_a[g]  = s_w_strb_i[g*STRB_W +: STRB_W];
    end

    assign req_s      = s_ar_valid_i | s_aw_valid_i;
    assign grant_oh_s = NUM_MST'(1'b1) << grant_q;
    assign next_ptr_s = (grant_q == IDX_W'(NUM_MST-1)) ? '0 : (grant_q + IDX_W'(1'b1));

    assign ar_hs_s = m_arvalid & m_arready;
    assign r_hs_s  = m_rvalid  & m_rready;
    assign aw_hs_s = m_awvalid & m_awready;
    assign w_hs_s  = m_wvalid  & m_wready;
    assign b_hs_s  = m_bvalid  & m_bready;

    axi_arb_rr_pick #(
        .NUM_REQ (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_s),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh_s),
        .idx_o    (pick_idx_s),
        .valid_o  (pick_valid_s)
    );

    // Channel muxing: connect only the granted master, everything else idles at 0
    always_comb begin
        m_arvalid    = 1'b0;
        m_araddr     = '0;
        m_arsize     = 3'd0;
        m_arid       = '0;
        m_arlen      = 8'd0;
        m_arburst    = 2'b00;
        m_rready     = 1'b0;
        m_awvalid    = 1'b0;
        m_awaddr     = '0;
        m_awsize     = 3'd0;
        m_awid       = '0;
        m_awlen      = 8'd0;
        m_awburst    = 2'b00;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = '0;
        m_wlast      = 1'b0;
        m_bready     = 1'b0;
        s_ar_ready_o = '0;
        s_r_valid_o  = '0;
        s_r_data_o   = '0;
        s_r_resp_o   = 2'b00;
        s_aw_ready_o = '0;
        s_w_ready_o  = '0;
        s_b_valid_o  = '0;
        s_b_resp_o   = 2'b00;
        case (state_q)
            ST_RD_A: begin
                m_arvalid    = 1'b1;
                m_araddr     = ar_addr_a[grant_q];
                m_arsize     = ar_size_a[grant_q];
                m_arid       = ID_W'(grant_q);
                m_arlen      = AXI_LEN_SINGLE;
                m_arburst    = AXI_BURST_INCR;
                s_ar_ready_o = grant_oh_s & {NUM_MST{m_arready}};
            end
            ST_RD_D: begin
                m_rready    = s_r_ready_i[grant_q];
                s_r_valid_o = grant_oh_s & {NUM_MST{m_rvalid}};
                s_r_data_o  = m_rvalid ? m_rdata : '0;
                s_r_resp_o  = m_rvalid ? m_rresp : 2'b00;
            end
            ST_WR_AW: begin
                m_awvalid    = ~aw_done_q;
                m_awaddr     = aw_addr_a[grant_q];
                m_awsize     = aw_size_a[grant_q];
                m_awid       = ID_W'(grant_q);
                m_awlen      = AXI_LEN_SINGLE;
                m_awburst    = AXI_BURST_INCR;
                m_wvalid     = s_w_valid_i[grant_q] & ~w_done_q;
                m_wdata      = w_data_a[grant_q];
                m_wstrb      = w_strb_a[grant_q];
                m_wlast      = 1'b1;
                s_aw_ready_o = grant_oh_s & {NUM_MST{m_awready & ~aw_done_q}};
                s_w_ready_o  = grant_oh_s & {NUM_MST{m_wready & ~w_done_q}};
            end
            ST_WR_B: begin
                m_bready    = s_b_ready_i[grant_q];
                s_b_valid_o = grant_oh_s & {NUM_MST{m_bvalid}};
                s_b_resp_o  = m_bvalid ? m_bresp : 2'b00;
            end
            default: begin
                m_arvalid = 1'b0;
            end
        endcase
    end

    // Transaction sequencing, grant selection and pointer rotation
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_idx_s;
                    state_d = (|(s_ar_valid_i & pick_oh_s)) ? ST_RD_A : ST_WR_AW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_A: begin
                if (ar_hs_s) begin
                    state_d = ST_RD_D;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_D: begin
                if (r_hs_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = ST_RD_D;
                end
            end
            ST_WR_AW: begin
                aw_done_d = aw_done_q | aw_hs_s;
                w_done_d  = w_done_q | w_hs_s;
                if (aw_done_d & w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_B;
                end else begin
                    state_d = ST_WR_AW;
                end
            end
            ST_WR_B: begin
                if (b_hs_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = ST_WR_B;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_arb.sv
// Directed bench for axi_arb: a two-master instance driven cycle by cycle and
// a three-master instance with a zero-wait slave for rotation fairness.
module tb_axi_arb;
    import axi_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;
    logic rst3;
    int   n_vec = 0;
    int   n_err = 0;

    // two-master instance
    logic [1:0]  s_ar_valid_i, s_ar_ready_o, s_r_valid_o, s_r_ready_i;
    logic [63:0] s_ar_addr_i, s_aw_addr_i, s_w_data_i;
    logic [5:0]  s_ar_size_i, s_aw_size_i;
    logic [31:0] s_r_data_o;
    logic [1:0]  s_r_resp_o, s_b_resp_o;
    logic [1:0]  s_aw_valid_i, s_aw_ready_o, s_w_valid_i, s_w_ready_o, s_b_valid_o, s_b_ready_i;
    logic [7:0]  s_w_strb_i;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [3:0]  m_awid, m_bid, m_arid, m_rid, m_wstrb;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;

    // three-master instance outputs
    logic [2:0]  t_ar_ready, t_r_valid, t_aw_ready, t_w_ready, t_b_valid;
    logic [31:0] t_r_data, t_awaddr, t_araddr, t_wdata;
    logic [1:0]  t_r_resp, t_b_resp, t_awburst, t_arburst;
    logic        t_awvalid, t_wvalid, t_wlast, t_bready, t_arvalid, t_rready;
    logic [3:0]  t_awid, t_arid, t_wstrb;
    logic [7:0]  t_awlen, t_arlen;
    logic [2:0]  t_awsize, t_arsize;

    logic [14:0] hs_vec;
    assign hs_vec = {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                     s_ar_ready_o, s_r_valid_o, s_aw_ready_o, s_w_ready_o, s_b_valid_o};

    axi_arb #(.NUM_MST(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .s_ar_valid_i(s_ar_valid_i), .s_ar_addr_i(s_ar_addr_i), .s_ar_size_i(s_ar_size_i), .s_ar_ready_o(s_ar_ready_o),
        .s_r_valid_o(s_r_valid_o), .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o), .s_r_ready_i(s_r_ready_i),
        .s_aw_valid_i(s_aw_valid_i), .s_aw_addr_i(s_aw_addr_i), .s_aw_size_i(s_aw_size_i), .s_aw_ready_o(s_aw_ready_o),
        .s_w_valid_i(s_w_valid_i), .s_w_data_i(s_w_data_i), .s_w_strb_i(s_w_strb_i), .s_w_ready_o(s_w_ready_o),
        .s_b_valid_o(s_b_valid_o), .s_b_resp_o(s_b_resp_o), .s_b_ready_i(s_b_ready_i),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    axi_arb #(.NUM_MST(3), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst3),
        .s_ar_valid_i(3'b111), .s_ar_addr_i(96'h8000_0200_8000_0100_8000_0000), .s_ar_size_i(9'o222),
        .s_ar_ready_o(t_ar_ready),
        .s_r_valid_o(t_r_valid), .s_r_data_o(t_r_data), .s_r_resp_o(t_r_resp), .s_r_ready_i(3'b111),
        .s_aw_valid_i(3'b000), .s_aw_addr_i(96'h0), .s_aw_size_i(9'h0), .s_aw_ready_o(t_aw_ready),
        .s_w_valid_i(3'b000), .s_w_data_i(96'h0), .s_w_strb_i(12'h0), .s_w_ready_o(t_w_ready),
        .s_b_valid_o(t_b_valid), .s_b_resp_o(t_b_resp), .s_b_ready_i(3'b000),
        .m_awvalid(t_awvalid), .m_awready(1'b0), .m_awid(t_awid), .m_awaddr(t_awaddr), .m_awlen(t_awlen),
        .m_awsize(t_awsize), .m_awburst(t_awburst),
        .m_wvalid(t_wvalid), .m_wready(1'b0), .m_wdata(t_wdata), .m_wstrb(t_wstrb), .m_wlast(t_wlast),
        .m_bvalid(1'b0), .m_bready(t_bready), .m_bid(4'h0), .m_bresp(2'b00),
        .m_arvalid(t_arvalid), .m_arready(1'b1), .m_arid(t_arid), .m_araddr(t_araddr), .m_arlen(t_arlen),
        .m_arsize(t_arsize), .m_arburst(t_arburst),
        .m_rvalid(1'b1), .m_rready(t_rready), .m_rid(4'h0), .m_rdata(32'h0000_0413), .m_rresp(2'b00), .m_rlast(1'b1)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read with a zero-wait slave (m_arready and m_rvalid already high)
    task automatic rd_txn(input int g, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        tick();
        check_vec("rd_arvalid", 64'(m_arvalid), 64'd1);
        check_vec("rd_arid", 64'(m_arid), 64'(g));
        check_vec("rd_araddr", 64'(m_araddr), 64'(exp_addr));
        tick();
        s_ar_valid_i[g] = 1'b0;
        #1;
        check_vec("rd_rroute", 64'(s_r_valid_o), 64'(2'b01 << g));
        check_vec("rd_rdata", 64'(s_r_data_o), 64'(exp_data));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_i = 1'b0; rst3 = 1'b0;
        s_ar_valid_i = 2'b00; s_ar_addr_i = 64'h0; s_ar_size_i = 6'h0; s_r_ready_i = 2'b00;
        s_aw_valid_i = 2'b00; s_aw_addr_i = 64'h0; s_aw_size_i = 6'h0;
        s_w_valid_i = 2'b00; s_w_data_i = 64'h0; s_w_strb_i = 8'h0; s_b_ready_i = 2'b00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = 4'h0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = 4'h0; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b1;
        repeat (2) tick();

        // reset state
        check_vec("rst_hs", 64'(hs_vec), 64'd0);
        check_vec("rst_addr", {m_araddr, m_awaddr}, 64'd0);
        check_vec("rst_id", 64'({m_arid, m_awid}), 64'd0);
        rst_i = 1'b1;

        // single read, IFU, two wait cycles on r
        s_ar_addr_i[31:0] = 32'h8000_0000; s_ar_size_i[2:0] = 3'd2;
        s_ar_valid_i = 2'b01; m_arready = 1'b1; s_r_ready_i = 2'b11;
        #1;
        check_vec("lat_idle_arvalid", 64'(m_arvalid), 64'd0);
        tick();
        check_vec("sr_arvalid", 64'(m_arvalid), 64'd1);
        check_vec("sr_arid", 64'(m_arid), 64'd0);
        check_vec("sr_arlen", 64'(m_arlen), 64'd0);
        check_vec("sr_arburst", 64'(m_arburst), 64'd1);
        check_vec("sr_araddr", 64'(m_araddr), 64'h8000_0000);
        check_vec("sr_arsize", 64'(m_arsize), 64'd2);
        check_vec("sr_arready_route", 64'(s_ar_ready_o), 64'b01);
        tick();
        s_ar_valid_i = 2'b00; m_rvalid = 1'b0;
        #1;
        check_vec("sr_wait1_rvalid", 64'(s_r_valid_o), 64'd0);
        check_vec("sr_rready", 64'(m_rready), 64'd1);
        tick();
        check_vec("sr_wait2_rvalid", 64'(s_r_valid_o), 64'd0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0413;
        #1;
        check_vec("sr_rvalid_route", 64'(s_r_valid_o), 64'b01);
        check_vec("sr_rdata", 64'(s_r_data_o), 64'h0000_0413);
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h0; m_arready = 1'b0;
        #1;
        check_vec("sr_done_hs", 64'(hs_vec), 64'd0);
        check_vec("sr_done_state", 64'(dut0.state_q), 64'(ST_IDLE));

        // single write, LSU, w accepted two cycles before aw
        s_aw_addr_i[63:32] = 32'h8000_1000; s_aw_size_i[5:3] = 3'd2;
        s_w_data_i[63:32] = 32'hdead_beef; s_w_strb_i[7:4] = 4'b0011;
        s_aw_valid_i = 2'b10; s_w_valid_i = 2'b10; m_wready = 1'b1; s_b_ready_i = 2'b11;
        tick();
        check_vec("sw_awvalid", 64'(m_awvalid), 64'd1);
        check_vec("sw_awid", 64'(m_awid), 64'd1);
        check_vec("sw_awaddr", 64'(m_awaddr), 64'h8000_1000);
        check_vec("sw_awlen", 64'(m_awlen), 64'd0);
        check_vec("sw_awburst", 64'(m_awburst), 64'd1);
        check_vec("sw_wvalid", 64'(m_wvalid), 64'd1);
        check_vec("sw_wlast", 64'(m_wlast), 64'd1);
        check_vec("sw_wdata", 64'(m_wdata), 64'hdead_beef);
        check_vec("sw_wstrb", 64'(m_wstrb), 64'h3);
        check_vec("sw_wready_route", 64'(s_w_ready_o), 64'b10);
        check_vec("sw_awready_held", 64'(s_aw_ready_o), 64'b00);
        tick();
        s_w_valid_i = 2'b00; m_wready = 1'b0;
        #1;
        check_vec("sw_wvalid_drop", 64'(m_wvalid), 64'd0);
        check_vec("sw_awvalid_hold", 64'(m_awvalid), 64'd1);
        tick();
        m_awready = 1'b1;
        #1;
        check_vec("sw_awready_route", 64'(s_aw_ready_o), 64'b10);
        tick();
        s_aw_valid_i = 2'b00; m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
        #1;
        check_vec("sw_awvalid_drop", 64'(m_awvalid), 64'd0);
        check_vec("sw_bvalid_route", 64'(s_b_valid_o), 64'b10);
        check_vec("sw_bready", 64'(m_bready), 64'd1);
        tick();
        m_bvalid = 1'b0;
        #1;
        check_vec("sw_done_hs", 64'(hs_vec), 64'd0);

        // contention from reset: 0, then 1, then 0 again
        rst_i = 1'b0;
        s_ar_addr_i = {32'h8000_2000, 32'h8000_3000}; s_ar_valid_i = 2'b11;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0011;
        tick();
        rst_i = 1'b1;
        rd_txn(0, 32'h8000_3000, 32'h0000_0011);
        rd_txn(1, 32'h8000_2000, 32'h0000_0011);
        s_ar_valid_i = 2'b11;
        rd_txn(0, 32'h8000_3000, 32'h0000_0011);
        s_ar_valid_i = 2'b00; m_rvalid = 1'b0; m_arready = 1'b0;

        // SLVERR write from LSU with aw and w accepted in the same cycle
        s_aw_valid_i = 2'b10; s_w_valid_i = 2'b10; m_awready = 1'b1; m_wready = 1'b1;
        tick();
        check_vec("er_grant_aw", 64'({s_aw_ready_o, s_w_ready_o}), 64'b1010);
        tick();
        s_aw_valid_i = 2'b00; s_w_valid_i = 2'b00; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        check_vec("er_bvalid_route", 64'(s_b_valid_o), 64'b10);
        check_vec("er_bresp", 64'(s_b_resp_o), 64'h2);
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        #1;
        check_vec("er_idle", 64'(dut0.state_q), 64'(ST_IDLE));
        check_vec("er_bresp_idle", 64'(s_b_resp_o), 64'h0);

        // reset during RD_D, then a clean read
        s_ar_addr_i[31:0] = 32'h8000_0040; s_ar_valid_i = 2'b01; m_arready = 1'b1;
        tick();
        tick();
        s_ar_valid_i = 2'b00;
        #1;
        check_vec("rm_pre_rready", 64'(m_rready), 64'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check_vec("rm_hs_cleared", 64'(hs_vec), 64'd0);
        check_vec("rm_state", 64'(dut0.state_q), 64'(ST_IDLE));
        tick();
        rst_i = 1'b1; s_ar_valid_i = 2'b01; m_rvalid = 1'b1; m_rdata = 32'h0000_0123;
        rd_txn(0, 32'h8000_0040, 32'h0000_0123);
        s_ar_valid_i = 2'b00; m_rvalid = 1'b0; m_arready = 1'b0;

        // three masters requesting continuously: strict rotation
        rst3 = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 30; c++) begin
            @(negedge clk);
            if (t_r_valid != 3'b000) begin
                check_vec("fair_rroute", 64'(t_r_valid), 64'(3'b001 << ((cnt - 1) % 3)));
            end
            if (t_arvalid) begin
                check_vec("fair_arid", 64'(t_arid), 64'(cnt % 3));
                cnt++;
            end
        end
        check_vec("fair_count", 64'(cnt), 64'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
